// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory access unit: access size encoding,
// data-path FSM states, byte-enable mask and load sign extension.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT2 = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Byte-enable pattern of an access, LSB-aligned.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            SZ_WORD: size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    // Number of bytes touched by an access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

    // Mask an LSB-aligned value to the access size, optionally sign-extending.
    function automatic logic [31:0] sext(input logic [31:0] v, input logic [1:0] size,
                                         input logic sgn);
        case (size)
            SZ_BYTE: sext = sgn ? {{24{v[7]}}, v[7:0]} : {24'h000000, v[7:0]};
            SZ_HALF: sext = sgn ? {{16{v[15]}}, v[15:0]} : {16'h0000, v[15:0]};
            SZ_WORD: sext = v;
            default: sext = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane steering: places store data and byte enables across
// a two-beat window, and extracts/extends load data from a two-beat window.
module lane_align
    import mem_pkg::*;
#(
    parameter  int BEAT_BYTES = 8,
    localparam int BW         = 8 * BEAT_BYTES,
    localparam int OFF_W      = $clog2(BEAT_BYTES)
) (
    input  logic [OFF_W-1:0]        st_off,
    input  logic [1:0]              st_size,
    input  logic [31:0]             st_wdata,
    output logic [2*BW-1:0]         st_data,
    output logic [2*BEAT_BYTES-1:0] st_be,
    input  logic [OFF_W-1:0]        ld_off,
    input  logic [1:0]              ld_size,
    input  logic                    ld_signed,
    input  logic [2*BW-1:0]         ld_beats,
    output logic [31:0]             ld_data
);

    logic [2*BW-1:0] ld_shift_s;
    logic            unused_s;

    // Store side: low half of the window is the addressed beat, high half the next one.
    always_comb begin
        st_data = {{(2*BW-32){1'b0}}, st_wdata} << {st_off, 3'b000};
        st_be   = {{(2*BEAT_BYTES-4){1'b0}}, size_mask(st_size)} << st_off;
    end

    // Load side: {high, low} window shifted down to the offset, then sized.
    always_comb begin
        ld_shift_s = ld_beats >> {ld_off, 3'b000};
        ld_data    = sext(ld_shift_s[31:0], ld_size, ld_signed);
    end

    assign unused_s = ^ld_shift_s[2*BW-1:32];

endmodule

// File: rtl/mem_access_unit.sv
// Core-side memory front end: fetch through a one-beat buffer on RAM port A,
// loads/stores with alignment and optional two-beat splitting on RAM port B.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter  int BEAT_BYTES = 8,
    parameter  int ADDR_W     = 14,
    parameter  bit MISALIGNED = 1'b1,
    localparam int BW         = 8 * BEAT_BYTES,
    localparam int OFF_W      = $clog2(BEAT_BYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    input  logic                  if_flush,
    output logic [31:0]           if_rdata,
    output logic                  if_valid,
    output logic                  if_err,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_a_en,
    output logic [ADDR_W-1:0]     ram_a_addr,
    input  logic [BW-1:0]         ram_a_rdata,
    output logic                  ram_b_en,
    output logic [BEAT_BYTES-1:0] ram_b_we,
    output logic [ADDR_W-1:0]     ram_b_addr,
    output logic [BW-1:0]         ram_b_wdata,
    input  logic [BW-1:0]         ram_b_rdata
);

    // Select the 32-bit word at a word-aligned byte offset within a beat.
    function automatic logic [31:0] pick_word(input logic [BW-1:0] beat,
                                              input logic [OFF_W-1:0] off);
        logic [BW-1:0] sh;
        sh = beat >> {off, 3'b000};
        return sh[31:0];
    endfunction

    // ---------------- data path signals ----------------
    state_e                  state_r, state_nx;
    logic [ADDR_W-1:0]       lat_idx_r;
    logic [OFF_W-1:0]        lat_off_r;
    logic [1:0]              lat_size_r;
    logic                    lat_signed_r, lat_store_r, lat_err_r, lat_split_r;
    logic [31:0]             lat_wdata_r;
    logic [BW-1:0]           low_beat_r;

    logic [OFF_W-1:0]        r_off_s;
    logic [ADDR_W-1:0]       r_idx_s;
    logic [4:0]              end_s;
    logic                    cross_s, err_s, accept_s;
    logic [OFF_W-1:0]        st_off_s;
    logic [1:0]              st_size_s;
    logic [31:0]             st_wdata_s;
    logic [2*BW-1:0]         st_data_s, ld_beats_s;
    logic [2*BEAT_BYTES-1:0] st_be_s;
    logic [31:0]             ld_data_s;
    logic                    b_en_s, b_write_s;
    logic [BEAT_BYTES-1:0]   b_we_s;
    logic [ADDR_W-1:0]       b_addr_s;
    logic [BW-1:0]           b_wdata_s;

    // ---------------- fetch signals ----------------
    logic                    buf_valid_r;
    logic [ADDR_W-1:0]       buf_tag_r;
    logic [BW-1:0]           buf_data_r;
    logic                    fill_pend_r, miss_r, if_valid_r, if_err_r;
    logic [ADDR_W-1:0]       pend_tag_r;
    logic [OFF_W-1:0]        pend_off_r;
    logic [31:0]             hit_word_r;
    logic [ADDR_W-1:0]       f_idx_s;
    logic [OFF_W-1:0]        f_off_s;
    logic                    fill_s, buf_hit_s, byp_hit_s, hit_s, a_kill_s;
    logic                    unused_s;

    assign unused_s = ^{if_addr, req_addr};

    // ================= data request path =================
    assign r_off_s  = req_addr[OFF_W-1:0];
    assign r_idx_s  = req_addr[OFF_W +: ADDR_W];
    assign end_s    = 5'(r_off_s) + 5'(size_bytes(req_size));
    assign cross_s  = end_s > 5'(BEAT_BYTES);
    assign err_s    = (req_size == SZ_ILL) | (cross_s & ~MISALIGNED);
    assign accept_s = req_valid & (state_r == ST_IDLE);

    // Store steering uses the live request while idle, the latched one in BEAT2.
    assign st_off_s   = (state_r == ST_IDLE) ? r_off_s   : lat_off_r;
    assign st_size_s  = (state_r == ST_IDLE) ? req_size  : lat_size_r;
    assign st_wdata_s = (state_r == ST_IDLE) ? req_wdata : lat_wdata_r;

    // Split loads take the low beat from the capture register; single-beat loads use RAM data only.
    assign ld_beats_s = lat_split_r ? {ram_b_rdata, low_beat_r} : {ram_b_rdata, ram_b_rdata};

    lane_align #(.BEAT_BYTES(BEAT_BYTES)) u_lane_align (
        .st_off    (st_off_s),
        .st_size   (st_size_s),
        .st_wdata  (st_wdata_s),
        .st_data   (st_data_s),
        .st_be     (st_be_s),
        .ld_off    (lat_off_r),
        .ld_size   (lat_size_r),
        .ld_signed (lat_signed_r),
        .ld_beats  (ld_beats_s),
        .ld_data   (ld_data_s)
    );

    // Data FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Data FSM next state and port B drive.
    always_comb begin
        state_nx  = state_r;
        b_en_s    = 1'b0;
        b_we_s    = '0;
        b_addr_s  = '0;
        b_wdata_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (err_s) begin
                        state_nx = ST_RESP;
                    end else begin
                        b_en_s    = 1'b1;
                        b_addr_s  = r_idx_s;
                        b_we_s    = req_store ? st_be_s[BEAT_BYTES-1:0] : '0;
                        b_wdata_s = st_data_s[BW-1:0];
                        state_nx  = cross_s ? ST_BEAT2 : ST_RESP;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_BEAT2: begin
                b_en_s    = 1'b1;
                b_addr_s  = lat_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                b_we_s    = lat_store_r ? st_be_s[2*BEAT_BYTES-1:BEAT_BYTES] : '0;
                b_wdata_s = st_data_s[2*BW-1:BW];
                state_nx  = ST_RESP;
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Latch the accepted request and capture the low beat of a split load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_idx_r    <= '0;
            lat_off_r    <= '0;
            lat_size_r   <= 2'b00;
            lat_signed_r <= 1'b0;
            lat_store_r  <= 1'b0;
            lat_err_r    <= 1'b0;
            lat_split_r  <= 1'b0;
            lat_wdata_r  <= 32'h0000_0000;
            low_beat_r   <= '0;
        end else begin
            if (accept_s) begin
                lat_idx_r    <= r_idx_s;
                lat_off_r    <= r_off_s;
                lat_size_r   <= req_size;
                lat_signed_r <= req_signed;
                lat_store_r  <= req_store;
                lat_err_r    <= err_s;
                lat_split_r  <= cross_s & ~err_s;
                lat_wdata_r  <= req_wdata;
            end
            if (state_r == ST_BEAT2) begin
                low_beat_r <= ram_b_rdata;
            end
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign req_ready   = rst_n & (state_r == ST_IDLE);
    assign ram_b_en    = rst_n & b_en_s;
    assign ram_b_we    = rst_n ? b_we_s    : '0;
    assign ram_b_addr  = rst_n ? b_addr_s  : '0;
    assign ram_b_wdata = rst_n ? b_wdata_s : '0;
    assign b_write_s   = ram_b_en & (|ram_b_we);

    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_err   = (state_r == ST_RESP) & lat_err_r;
    assign rsp_rdata = ((state_r == ST_RESP) && !lat_err_r && !lat_store_r) ? ld_data_s : 32'h0000_0000;

    // ================= fetch path =================
    assign f_idx_s   = if_addr[OFF_W +: ADDR_W];
    assign f_off_s   = if_addr[OFF_W-1:0] & ~(OFF_W'(3));
    // A fill in flight is dropped by a flush or by a write to the same beat.
    assign fill_s    = fill_pend_r & ~if_flush & ~(b_write_s && (ram_b_addr == pend_tag_r));
    assign buf_hit_s = buf_valid_r && (buf_tag_r == f_idx_s);
    assign byp_hit_s = fill_s && (pend_tag_r == f_idx_s);
    assign hit_s     = buf_hit_s | byp_hit_s;
    // A same-cycle write to the requested beat means the returning data is stale.
    assign a_kill_s  = if_flush | (b_write_s && (ram_b_addr == f_idx_s));

    assign ram_a_en   = rst_n & if_req & ~hit_s;
    assign ram_a_addr = rst_n ? f_idx_s : '0;

    // Fetch request pipeline: response flags, pending fill and hit word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_r  <= 1'b0;
            if_err_r    <= 1'b0;
            miss_r      <= 1'b0;
            fill_pend_r <= 1'b0;
            pend_tag_r  <= '0;
            pend_off_r  <= '0;
            hit_word_r  <= 32'h0000_0000;
        end else begin
            if_valid_r  <= if_req;
            if_err_r    <= if_req & (if_addr[1:0] != 2'b00);
            miss_r      <= if_req & ~hit_s;
            fill_pend_r <= if_req & ~hit_s & ~a_kill_s;
            if (if_req) begin
                pend_tag_r <= f_idx_s;
                pend_off_r <= f_off_s;
                hit_word_r <= byp_hit_s ? pick_word(ram_a_rdata, f_off_s)
                                        : pick_word(buf_data_r, f_off_s);
            end
        end
    end

    // Fetch buffer: filled on miss return, invalidated by flush or a write to its beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_r <= 1'b0;
            buf_tag_r   <= '0;
            buf_data_r  <= '0;
        end else if (fill_s) begin
            buf_valid_r <= 1'b1;
            buf_tag_r   <= pend_tag_r;
            buf_data_r  <= ram_a_rdata;
        end else if (if_flush || (b_write_s && (ram_b_addr == buf_tag_r))) begin
            buf_valid_r <= 1'b0;
        end
    end

    assign if_valid = if_valid_r;
    assign if_err   = if_err_r;
    assign if_rdata = miss_r ? pick_word(ram_a_rdata, pend_off_r) : hit_word_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural dual-port RAM.
module tb_mem_access_unit;

    logic        clk, rst_n;
    logic        if_req, if_flush;
    logic [31:0] if_addr;
    logic        req_valid, req_store, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic [31:0] if_rdata, rsp_rdata;
    logic        if_valid, if_err, req_ready, rsp_valid, rsp_err;
    logic        ram_a_en, ram_b_en;
    logic [13:0] ram_a_addr, ram_b_addr;
    logic [7:0]  ram_b_we;
    logic [63:0] ram_b_wdata, a_rdata, b_rdata;

    logic [31:0] if_rdata_m0, rsp_rdata_m0;
    logic        if_valid_m0, if_err_m0, req_ready_m0, rsp_valid_m0, rsp_err_m0;
    logic        ram_a_en_m0, ram_b_en_m0;
    logic [13:0] ram_a_addr_m0, ram_b_addr_m0;
    logic [7:0]  ram_b_we_m0;
    logic [63:0] ram_b_wdata_m0;
    logic [63:0] zero_beat;

    logic        pl_en;
    logic [13:0] pl_addr;
    logic [63:0] pl_data;
    logic [63:0] mem [0:16383];

    int n_checks = 0;
    int n_errors = 0;

    assign zero_beat = 64'h0;

    mem_access_unit #(.BEAT_BYTES(8), .ADDR_W(14), .MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_a_en(ram_a_en), .ram_a_addr(ram_a_addr), .ram_a_rdata(a_rdata),
        .ram_b_en(ram_b_en), .ram_b_we(ram_b_we), .ram_b_addr(ram_b_addr),
        .ram_b_wdata(ram_b_wdata), .ram_b_rdata(b_rdata)
    );

    mem_access_unit #(.BEAT_BYTES(8), .ADDR_W(14), .MISALIGNED(1'b0)) dut_m0 (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata_m0), .if_valid(if_valid_m0), .if_err(if_err_m0),
        .req_valid(req_valid), .req_ready(req_ready_m0), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_m0), .rsp_rdata(rsp_rdata_m0), .rsp_err(rsp_err_m0),
        .ram_a_en(ram_a_en_m0), .ram_a_addr(ram_a_addr_m0), .ram_a_rdata(zero_beat),
        .ram_b_en(ram_b_en_m0), .ram_b_we(ram_b_we_m0), .ram_b_addr(ram_b_addr_m0),
        .ram_b_wdata(ram_b_wdata_m0), .ram_b_rdata(zero_beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM, one-cycle read latency, read-before-write, plus a preload port.
    always @(posedge clk) begin
        if (ram_a_en) a_rdata <= mem[ram_a_addr];
        if (ram_b_en) begin
            b_rdata <= mem[ram_b_addr];
            for (int i = 0; i < 8; i++)
                if (ram_b_we[i]) mem[ram_b_addr][8*i +: 8] <= ram_b_wdata[8*i +: 8];
        end
        if (pl_en) mem[pl_addr] <= pl_data;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic preload(input logic [13:0] a, input logic [63:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic drive(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
    endtask

    task automatic idle_req();
        req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
    endtask

    // Single-beat load: response at +1, never an error on either variant.
    task automatic do_load1(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic sg, input logic [31:0] exp, input logic [13:0] idx);
        next_cyc(); drive(1'b0, sz, sg, a, 32'h0);
        sample();
        chk({tag, "_ready"}, req_ready, 1'b1);
        chk({tag, "_baddr"}, ram_b_addr, idx);
        next_cyc(); idle_req();
        sample();
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        chk({tag, "_data"}, rsp_rdata, exp);
        chk({tag, "_err"}, rsp_err, 1'b0);
        chk({tag, "_m0err"}, rsp_err_m0, 1'b0);
        next_cyc(); sample();
        chk({tag, "_pulse"}, rsp_valid, 1'b0);
    endtask

    // Beat-crossing load: high beat at +1, response at +2.
    task automatic do_load2(input string tag, input logic [31:0] a,
                            input logic [31:0] exp, input logic [13:0] hi_idx);
        next_cyc(); drive(1'b0, 2'd2, 1'b0, a, 32'h0);
        next_cyc(); idle_req();
        sample();
        chk({tag, "_hiaddr"}, ram_b_addr, hi_idx);
        chk({tag, "_hien"}, ram_b_en, 1'b1);
        chk({tag, "_early"}, rsp_valid, 1'b0);
        next_cyc(); sample();
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        chk({tag, "_data"}, rsp_rdata, exp);
        next_cyc();
    endtask

    task automatic do_store1(input string tag, input logic [31:0] a, input logic [31:0] wd);
        next_cyc(); drive(1'b1, 2'd2, 1'b0, a, wd);
        next_cyc(); idle_req();
        sample();
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        next_cyc();
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0; pl_en = 1'b0;
        pl_addr = 14'h0; pl_data = 64'h0;
        idle_req();
        preload(14'd2, 64'h8077_6655_4433_2211);
        preload(14'd3, 64'h0);
        preload(14'd4, 64'h0);
        preload(14'd5, 64'h0);
        preload(14'd6, 64'h0);
        preload(14'd8, 64'h2222_2222_1111_1111);
        preload(14'd9, 64'h4444_4444_3333_3333);
        preload(14'h3FFF, 64'hA1B2_0000_0000_0000);
        preload(14'd0, 64'h0000_0000_0000_C3D4);

        sample();
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_b_en", ram_b_en, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        sample();
        chk("post_rst_ready", req_ready, 1'b1);

        // Loads within one beat.
        do_load1("lw10", 32'h10, 2'd2, 1'b0, 32'h4433_2211, 14'd2);
        do_load1("lb17s", 32'h17, 2'd0, 1'b1, 32'hFFFF_FF80, 14'd2);
        do_load1("lb17u", 32'h17, 2'd0, 1'b0, 32'h0000_0080, 14'd2);

        // Split store across beats 3/4; the no-split variant errors instead.
        next_cyc(); drive(1'b1, 2'd2, 1'b0, 32'h1E, 32'hDEAD_BEEF);
        sample();
        chk("sst_lo_we", ram_b_we, 8'hC0);
        chk("sst_lo_addr", ram_b_addr, 14'd3);
        chk("sst_lo_data", ram_b_wdata[63:48], 16'hBEEF);
        chk("m0_no_en", ram_b_en_m0, 1'b0);
        next_cyc(); idle_req();
        sample();
        chk("sst_hi_we", ram_b_we, 8'h03);
        chk("sst_hi_addr", ram_b_addr, 14'd4);
        chk("sst_hi_data", ram_b_wdata[15:0], 16'hDEAD);
        chk("sst_no_rsp", rsp_valid, 1'b0);
        chk("m0_rsp_valid", rsp_valid_m0, 1'b1);
        chk("m0_rsp_err", rsp_err_m0, 1'b1);
        chk("m0_rsp_data", rsp_rdata_m0, 32'h0);
        next_cyc(); sample();
        chk("sst_rsp", rsp_valid, 1'b1);
        chk("sst_rsp_err", rsp_err, 1'b0);
        chk("sst_rsp_data", rsp_rdata, 32'h0);
        next_cyc();

        do_load2("lw1e", 32'h1E, 32'hDEAD_BEEF, 14'd4);
        do_load1("lh1e", 32'h1E, 2'd1, 1'b1, 32'hFFFF_BEEF, 14'd3);
        do_load2("lwrap", 32'h0001_FFFE, 32'hC3D4_A1B2, 14'd0);

        // Illegal size.
        next_cyc(); drive(1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
        sample();
        chk("ill_no_en", ram_b_en, 1'b0);
        next_cyc(); idle_req();
        sample();
        chk("ill_valid", rsp_valid, 1'b1);
        chk("ill_err", rsp_err, 1'b1);
        chk("ill_data", rsp_rdata, 32'h0);
        next_cyc();

        // Fetch 0x40 then 0x44: only the first touches the RAM.
        next_cyc(); if_req = 1'b1; if_addr = 32'h40;
        sample();
        chk("f40_en", ram_a_en, 1'b1);
        chk("f40_addr", ram_a_addr, 14'd8);
        next_cyc(); if_addr = 32'h44;
        sample();
        chk("f40_valid", if_valid, 1'b1);
        chk("f40_data", if_rdata, 32'h1111_1111);
        chk("f44_en", ram_a_en, 1'b0);
        next_cyc(); if_req = 1'b0;
        sample();
        chk("f44_valid", if_valid, 1'b1);
        chk("f44_data", if_rdata, 32'h2222_2222);
        chk("f44_err", if_err, 1'b0);
        next_cyc(); sample();
        chk("f_idle_valid", if_valid, 1'b0);

        // Store into the buffered beat invalidates it.
        do_store1("st44", 32'h44, 32'h1234_5678);
        next_cyc(); if_req = 1'b1; if_addr = 32'h40;
        sample();
        chk("inv_refetch", ram_a_en, 1'b1);
        next_cyc(); if_addr = 32'h44;
        next_cyc(); if_req = 1'b0;
        sample();
        chk("inv_data", if_rdata, 32'h1234_5678);

        // Store to 0x48, then fetch 0x4C refetches.
        do_store1("st48", 32'h48, 32'h5566_7788);
        next_cyc(); if_req = 1'b1; if_addr = 32'h4C;
        sample();
        chk("f4c_en", ram_a_en, 1'b1);
        next_cyc(); if_req = 1'b0;
        sample();
        chk("f4c_data", if_rdata, 32'h4444_4444);

        // Misaligned fetch address.
        next_cyc(); if_req = 1'b1; if_addr = 32'h42;
        next_cyc(); if_req = 1'b0;
        sample();
        chk("f42_err", if_err, 1'b1);
        next_cyc(); sample();
        chk("f42_err_clr", if_err, 1'b0);

        // Hit, then flush forces a refetch.
        next_cyc(); if_req = 1'b1; if_addr = 32'h40;
        sample();
        chk("flush_pre_hit", ram_a_en, 1'b0);
        next_cyc(); if_req = 1'b0; if_flush = 1'b1;
        next_cyc(); if_flush = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        sample();
        chk("flush_refetch", ram_a_en, 1'b1);
        next_cyc(); if_req = 1'b0;

        // Reset during BEAT2 of a split store to beats 5/6.
        next_cyc(); drive(1'b1, 2'd2, 1'b0, 32'h2E, 32'hCAFE_F00D);
        sample();
        chk("rb_lo_we", ram_b_we, 8'hC0);
        next_cyc(); idle_req();
        #1;
        chk("rb_hi_en", ram_b_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rb_en_off", ram_b_en, 1'b0);
        chk("rb_we_off", ram_b_we, 8'h00);
        chk("rb_ready_off", req_ready, 1'b0);
        chk("rb_rsp_off", rsp_valid, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("rb_no_rsp", rsp_valid, 1'b0);
            next_cyc();
        end
        chk("rb_mem_lo", mem[5], 64'hF00D_0000_0000_0000);
        chk("rb_mem_hi", mem[6], 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
